// File: rtl/data_mem_ctrl_if.sv
// MEM-stage to data-memory bus: request fields from the core, response and stall back.
interface data_mem_ctrl_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;

  modport master (output req, we, funct3, addr, wdata,
                  input  ready, rdata, stall, misalign);
  modport slave  (input  req, we, funct3, addr, wdata,
                  output ready, rdata, stall, misalign);
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I data-memory controller: wait-state handshake, lane steering, sign/zero extension.
// Optional macro DMEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning.
//
// state | meaning
// IDLE  | waiting for req; latches request fields
// WAIT  | counting down wait states; inputs ignored
// RESP  | ready pulse, rdata/misalign valid
module data_mem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  data_mem_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic        ready_q, mis_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [DEPTH];

  logic        use_live, commit, is_h, is_w, trap, src_we;
  logic [2:0]  src_f3;
  logic [31:0] src_addr, src_wdata, old_w, sh_w, wd, rdata_d;
  logic [1:0]  lo;
  logic [3:0]  be;
  logic [AW-1:0] idx;
  logic        unused_addr;

  // With zero wait states the commit edge is the IDLE sample edge, so use live inputs.
  assign use_live  = (state_q == S_IDLE);
  assign src_we    = use_live ? bus.we     : we_q;
  assign src_f3    = use_live ? bus.funct3 : f3_q;
  assign src_addr  = use_live ? bus.addr   : addr_q;
  assign src_wdata = use_live ? bus.wdata  : wdata_q;
  assign commit    = ((state_q == S_IDLE) && bus.req && (WAIT_STATES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == 3'd1));

  assign is_h        = (src_f3[1:0] == 2'b01);
  assign is_w        = src_f3[1];
  assign idx         = src_addr[AW+1:2];
  assign old_w       = mem_q[idx];
  assign unused_addr = ^src_addr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign lo   = src_addr[1:0];
  assign trap = (is_h && src_addr[0]) || (is_w && (src_addr[1:0] != 2'b00));
`else
  assign lo   = is_w ? 2'b00 : (is_h ? {src_addr[1], 1'b0} : src_addr[1:0]);
  assign trap = 1'b0;
`endif

  assign sh_w = old_w >> {lo, 3'b000};

  always_comb begin
    be      = 4'b0000;
    wd      = src_wdata;
    rdata_d = 32'h0;
    if (is_w) begin
      be      = 4'b1111;
      rdata_d = old_w;
    end else if (is_h) begin
      be      = lo[1] ? 4'b1100 : 4'b0011;
      wd      = {2{src_wdata[15:0]}};
      rdata_d = {{16{~src_f3[2] & sh_w[15]}}, sh_w[15:0]};
    end else begin
      be      = 4'b0001 << lo;
      wd      = {4{src_wdata[7:0]}};
      rdata_d = {{24{~src_f3[2] & sh_w[7]}}, sh_w[7:0]};
    end
    if (src_we || trap) rdata_d = 32'h0;
  end

  // Gated by reset_i so a request held during reset never commits a store.
  always_ff @(posedge clk_i) begin
    if (reset_i && commit && src_we && !trap) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.req) begin
          we_q    <= bus.we;
          f3_q    <= bus.funct3;
          addr_q  <= bus.addr;
          wdata_q <= bus.wdata;
          cnt_q   <= 3'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            mis_q   <= trap;
            rdata_q <= rdata_d;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            mis_q   <= trap;
            rdata_q <= rdata_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.rdata    = rdata_q;
  assign bus.misalign = mis_q;
  assign bus.stall    = bus.req && !ready_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (1, 3 and 0 wait states) checked by a byte-level model.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        req_v [3], we_v [3], rst_v [3];
  logic [2:0]  f3_v  [3];
  logic [31:0] a_v   [3], wd_v [3];
  logic        rdy_v [3], stl_v [3], mis_v [3];
  logic [31:0] rd_v  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_ctrl_if bus ();
    assign bus.req    = req_v[g];
    assign bus.we     = we_v[g];
    assign bus.funct3 = f3_v[g];
    assign bus.addr   = a_v[g];
    assign bus.wdata  = wd_v[g];
    assign rdy_v[g]   = bus.ready;
    assign stl_v[g]   = bus.stall;
    assign mis_v[g]   = bus.misalign;
    assign rd_v[g]    = bus.rdata;
    data_mem_ctrl #(.DEPTH(1024), .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 3 : 0))) dut (
      .clk_i(clk), .reset_i(rst_v[g]), .bus(bus));
  end

  int n_cmp = 0, n_bad = 0;

  function automatic int wsof(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  function automatic int sz(logic [2:0] f);
    return (f[1:0] == 2'b00) ? 1 : ((f[1:0] == 2'b01) ? 2 : 4);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: memory as bytes, access timeline from the handshake rules.
  logic [7:0]  bm [3][4096];
  int          act [3] = '{0, 0, 0};
  int          cnt [3] = '{0, 0, 0};
  logic        o_we [3];
  logic [2:0]  o_f3 [3];
  logic [31:0] o_a [3], o_wd [3];
  logic [31:0] m_rd [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int ws, s, ba;
      logic e_rdy, e_mis, trap;
      logic [31:0] v;
      ws = wsof(k);
      if (!rst_v[k]) begin
        act[k] = 0; cnt[k] = 0; m_rd[k] = 32'h0;
      end else begin
        if (act[k] != 0) begin
          cnt[k]++;
          if (cnt[k] == ws + 2) act[k] = 0;
        end
        if (act[k] == 0 && req_v[k]) begin
          act[k] = 1; cnt[k] = 0;
          o_we[k] = we_v[k]; o_f3[k] = f3_v[k]; o_a[k] = a_v[k]; o_wd[k] = wd_v[k];
        end
      end
      e_rdy = (act[k] != 0) && (cnt[k] == ws + 1);
      e_mis = 1'b0;
      if (e_rdy) begin
        s  = sz(o_f3[k]);
        ba = int'(o_a[k][11:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
        trap = (ba % s) != 0;
`else
        trap = 1'b0;
        ba   = ba - (ba % s);
`endif
        if (trap) begin
          m_rd[k] = 32'h0; e_mis = 1'b1;
        end else if (o_we[k]) begin
          for (int j = 0; j < s; j++) bm[k][ba + j] = o_wd[k][8*j +: 8];
          m_rd[k] = 32'h0;
        end else begin
          v = 32'h0;
          for (int j = 0; j < s; j++) v[8*j +: 8] = bm[k][ba + j];
          if (s < 4 && !o_f3[k][2] && v[8*s-1]) v = v | ~((32'h1 << (8*s)) - 32'h1);
          m_rd[k] = v;
        end
      end
      chk($sformatf("ready[%0d]", k), {31'h0, rdy_v[k]}, {31'h0, e_rdy});
      chk($sformatf("stall[%0d]", k), {31'h0, stl_v[k]}, {31'h0, req_v[k] && !e_rdy});
      chk($sformatf("misalign[%0d]", k), {31'h0, mis_v[k]}, {31'h0, e_mis});
      chk($sformatf("rdata[%0d]", k), rd_v[k], m_rd[k]);
    end
  end

  // Issue one access from posedge+1; leaves req low at posedge+1 after the ready cycle.
  task automatic access(int k, logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                        logic [31:0] exp_rd, string name);
    int lat, stc;
    logic [31:0] got;
    logic seen;
    req_v[k] = 1'b1; we_v[k] = w; f3_v[k] = f3; a_v[k] = a; wd_v[k] = wd;
    lat = 0; stc = 0; seen = 1'b0; got = 32'h0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (stl_v[k]) stc++;
      if (rdy_v[k]) begin seen = 1'b1; lat = i; got = rd_v[k]; end
    end
    if (!seen) chk({name, "_timeout"}, 32'h0, 32'h1);
    chk({name, "_latency"}, lat, wsof(k) + 1);
    chk({name, "_stallcyc"}, stc, wsof(k) + 1);
    chk({name, "_rdata"}, got, exp_rd);
    @(posedge clk); #1;
    req_v[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b0; req_v[k] = 1'b0; we_v[k] = 1'b0;
      f3_v[k] = 3'd0; a_v[k] = 32'h0; wd_v[k] = 32'h0;
    end
    req_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_stall_follows_req", {31'h0, stl_v[0]}, 32'h1);
    chk("reset_ready", {31'h0, rdy_v[0]}, 32'h0);
    chk("reset_rdata", rd_v[0], 32'h0);
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rst_v[k] = 1'b1;
    @(posedge clk); #1;

    // 1 wait state: lanes, extension, wrap, misalignment
    access(0, 1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        "sw10");
    access(0, 0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, "lw10a");
    access(0, 1, 3'b000, 32'h11,   32'h0000007F, 32'h0,        "sb11");
    access(0, 0, 3'b000, 32'h11,   32'h0,        32'h0000007F, "lb11");
    access(0, 0, 3'b000, 32'h10,   32'h0,        32'hFFFFFFEF, "lb10");
    access(0, 0, 3'b100, 32'h10,   32'h0,        32'h000000EF, "lbu10");
    access(0, 1, 3'b001, 32'h12,   32'h00008001, 32'h0,        "sh12");
    access(0, 0, 3'b001, 32'h12,   32'h0,        32'hFFFF8001, "lh12");
    access(0, 0, 3'b101, 32'h12,   32'h0,        32'h00008001, "lhu12");
    access(0, 0, 3'b010, 32'h10,   32'h0,        32'h80017FEF, "lw10b");
    chk("model_pin_lw10", m_rd[0], 32'h80017FEF);
    access(0, 1, 3'b010, 32'h1000, 32'h12345678, 32'h0,        "sw1000");
    access(0, 0, 3'b010, 32'h0,    32'h0,        32'h12345678, "lw0");
    access(0, 0, 3'b011, 32'h0,    32'h0,        32'h12345678, "f3_011");
`ifdef DMEM_MISALIGN_TRAP_EN
    access(0, 0, 3'b010, 32'h13,   32'h0,        32'h0,        "lw13");
    access(0, 1, 3'b001, 32'h11,   32'h0,        32'h0,        "sh11");
    access(0, 0, 3'b010, 32'h10,   32'h0,        32'h80017FEF, "lw10c");
`else
    access(0, 0, 3'b010, 32'h13,   32'h0,        32'h80017FEF, "lw13");
    access(0, 1, 3'b001, 32'h11,   32'h0,        32'h0,        "sh11");
    access(0, 0, 3'b010, 32'h10,   32'h0,        32'h80010000, "lw10c");
`endif

    // 3 wait states: reset during second WAIT drops the store
    access(1, 1, 3'b010, 32'h20, 32'h01020304, 32'h0,        "w3_sw20");
    access(1, 0, 3'b010, 32'h20, 32'h0,        32'h01020304, "w3_lw20");
    req_v[1] = 1'b1; we_v[1] = 1'b1; f3_v[1] = 3'b010; a_v[1] = 32'h20; wd_v[1] = 32'hAAAA5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_v[1] = 1'b0; req_v[1] = 1'b0;
    #1;
    chk("w3_rst_ready", {31'h0, rdy_v[1]}, 32'h0);
    chk("w3_rst_rdata", rd_v[1], 32'h0);
    chk("w3_rst_stall", {31'h0, stl_v[1]}, 32'h0);
    chk("w3_rst_mis", {31'h0, mis_v[1]}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_v[1] = 1'b1;
    @(posedge clk); #1;
    access(1, 0, 3'b010, 32'h20, 32'h0,        32'h01020304, "w3_lw20_after");

    // 0 wait states: back-to-back
    access(2, 1, 3'b010, 32'h0, 32'h11111111, 32'h0,        "w0_sw0");
    access(2, 1, 3'b010, 32'h4, 32'h22A2B322, 32'h0,        "w0_sw4");
    access(2, 0, 3'b010, 32'h0, 32'h0,        32'h11111111, "w0_lw0");
    access(2, 0, 3'b010, 32'h4, 32'h0,        32'h22A2B322, "w0_lw4");
    access(2, 0, 3'b000, 32'h5, 32'h0,        32'hFFFFFFB3, "w0_lb5");
    access(2, 0, 3'b001, 32'h6, 32'h0,        32'h000022A2, "w0_lh6");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised RV32I data-memory controller that sits between the MEM stage of the pipelined core and an on-chip word array. It replaces the fixed single-cycle data memory. It adds configurable depth and wait states, and a req/ready handshake that drives a pipeline stall. It performs full RV32I byte/halfword/word loads and stores with lane steering and sign/zero extension, plus misalignment detection.

## Interface
- DEPTH, 1024, number of 32-bit words; power of two, 16..65536
- WAIT_STATES, 1, extra cycles per access; 0..7
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req  in  1  access request from MEM stage; held with addr/we/funct3/wdata stable until ready
- we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address
- wdata  in  32  store data; SB uses [7:0], SH uses [15:0]
- ready  out  1  one-cycle pulse: access complete, rdata valid
- rdata  out  32  load result, extended to 32 bits; 0 for stores
- stall  out  1  combinational req && !ready, to the hazard unit
- misalign  out  1  pulse with ready when the access was misaligned

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE with req=1: latch addr, we, funct3 and wdata, and load the counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else go to RESP.
  - WAIT: decrement the counter. At counter==1, go to RESP. Inputs are ignored.
  - RESP: ready=1. Always return to IDLE. No new request is accepted in RESP.
- Word index is addr[$clog2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Array read and store commit both occur on the edge entering RESP. A load issued after a store to the same word returns the new data.
- Stores:
  - SB writes byte lane addr[1:0].
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all lanes.
  - All other lanes are unchanged.
- Loads:
  - B/H select the same lanes as the matching store.
  - B/H sign-extend; BU/HU zero-extend.
- funct3 values 011, 110 and 111 are treated as word access.
- Misaligned accesses are halfword with addr[0]=1, or word with addr[1:0]≠0. Handling depends on the configuration macro below.
- rdata is registered. It updates only on entry to RESP and holds its value otherwise.
- Array contents are not affected by reset.

## Timing
- Latency: req sampled in IDLE at edge 0, ready high in cycle WAIT_STATES+1. Throughput is one access per WAIT_STATES+2 cycles.
- stall is high from the first req cycle until, but not including, the RESP cycle.
- Reset values: state IDLE, counter 0, ready 0, rdata 0, misalign 0. stall follows req, so it is 1 if req=1 during reset.
- Reset asserted mid-access: immediate return to IDLE. A pending store is dropped (array not written) and no ready pulse is issued.
- Requester protocol violation (req dropped during WAIT): the access still completes from latched values.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - Misaligned access completes the handshake with normal latency.
  - The array is not written, rdata=0, and misalign=1 in the RESP cycle.
- DMEM_MISALIGN_TRAP_EN undefined:
  - addr is force-aligned: halfword clears bit 0, word clears bits [1:0].
  - The access proceeds normally and misalign is tied 0.

## Test plan
- WAIT_STATES=1: SW 0xDEADBEEF to 0x10, then LW 0x10 → ready in cycle 2 of each access, rdata=0xDEADBEEF, stall high exactly 2 cycles per access.
- After the word above: SB 0x7F to 0x11, then LB 0x11 → 0x0000007F. SH 0x8001 to 0x12, then LH 0x12 → 0xFFFF8001, LHU 0x12 → 0x00008001, LW 0x10 → 0x80017FEF.
- DEPTH=1024: SW 0x12345678 to 0x1000 (wraps), then LW 0x0 → 0x12345678.
- LW 0x13:
  - With DMEM_MISALIGN_TRAP_EN: misalign=1, rdata=0, word 0x10 unchanged.
  - Without it: rdata equals the word at 0x10, misalign=0.
- WAIT_STATES=3: SW 0xAAAA5555 to 0x20, with reset asserted during the second WAIT cycle → no ready pulse, all outputs 0. A subsequent LW 0x20 returns the previous contents.
- WAIT_STATES=0: back-to-back LW requests → ready every 2nd cycle, stall high 1 cycle per access.
